toggle_counter: RTL

TOGGLE_COUNTER -- requirements
Module: toggle_counter

---
 rtl/toggle_counter.sv | 95 +++++++++
 1 files changed

// File: rtl/toggle_counter.sv
// Modulo-MODULUS up/down counter with registered toggle mask, terminal-count pulse and sticky wrap flag.
// Optional step prescaler is compiled in with TOGGLE_COUNTER_PRESCALE_EN.
module toggle_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             wrapped
);

  localparam int WIDTH_EXT = WIDTH + 1;
  localparam logic [WIDTH-1:0]     MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH_EXT-1:0] MOD_EXT   = WIDTH_EXT'(MODULUS);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH) || PRESCALE < 2) begin : g_param_check
    $error("toggle_counter: illegal MODULUS/PRESCALE for WIDTH");
  end

  logic             step;
  logic             wrap;
  logic [WIDTH-1:0] next_count;

`ifdef TOGGLE_COUNTER_PRESCALE_EN
  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre;

  // Load realigns the prescaler so the next step is a full PRESCALE enables away.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre <= '0;
    end else if (load) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == PRE_MAX) ? '0 : pre + PRE_W'(1);
    end
  end

  assign step = en && !load && (pre == PRE_MAX);
`else
  assign step = en && !load;
`endif

  always_comb begin
    next_count = count;
    wrap       = 1'b0;
    if (load) begin
      // Out-of-range load values clamp to the top of the range.
      next_count = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_COUNT;
    end else if (step) begin
      if (up) begin
        if (count == MAX_COUNT) begin
          next_count = '0;
          wrap       = 1'b1;
        end else begin
          next_count = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          next_count = MAX_COUNT;
          wrap       = 1'b1;
        end else begin
          next_count = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count   <= '0;
      t_vec   <= '0;
      tc      <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      count   <= next_count;
      t_vec   <= count ^ next_count;
      tc      <= wrap;
      // A wrap on the same edge as a clear wins.
      wrapped <= wrap | (wrapped & ~clr_wrap);
    end
  end

endmodule
